fetch_requester: RTL

FETCH_REQUESTER -- requirements
Module: fetch_requester

---
 rtl/fetch_requester.sv | 138 +++++++++++++
 1 files changed

// File: rtl/fetch_requester.sv
// Instruction fetch requester: issues one word read at a time to instruction memory
// and buffers returned words in a small FIFO, with branch redirect and flush.
module fetch_requester #(
  parameter int unsigned           ADDR_WIDTH = 8,
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           FIFO_DEPTH = 2,
  parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  instr_req_o,
  output logic [ADDR_WIDTH-1:0] instr_addr_o,
  input  logic                  instr_gnt_i,
  input  logic                  instr_rvalid_i,
  input  logic [DATA_WIDTH-1:0] instr_rdata_i,
  input  logic                  branch_i,
  input  logic [ADDR_WIDTH-1:0] branch_addr_i,
  output logic                  fetch_valid_o,
  output logic [DATA_WIDTH-1:0] fetch_rdata_o,
  output logic [ADDR_WIDTH-1:0] fetch_addr_o,
  input  logic                  fetch_ready_i,
  output logic                  busy_o
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RV} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [ADDR_WIDTH-1:0] tgt_q, tgt_d;
  logic                  discard_q, discard_d;
  logic [PW-1:0]         rptr_q, wptr_q;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_mem_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] data_mem_q [FIFO_DEPTH];

  logic                  push, pop;
  logic [ADDR_WIDTH-1:0] br_tgt;

  assign br_tgt        = branch_addr_i & ~ADDR_WIDTH'(3);
  assign fetch_valid_o = (cnt_q != '0);
  assign fetch_rdata_o = data_mem_q[rptr_q];
  assign fetch_addr_o  = addr_mem_q[rptr_q];
  assign instr_req_o   = (state_q == REQ);
  assign instr_addr_o  = pc_q;
  assign busy_o        = (state_q != IDLE);

  // Flush wins over both push and pop in the branch cycle.
  assign pop   = fetch_valid_o & fetch_ready_i & ~branch_i;
  assign push  = (state_q == WAIT_RV) & instr_rvalid_i & ~discard_q & ~branch_i;
  assign cnt_d = cnt_q + CW'(push) - CW'(pop);

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    tgt_d     = tgt_q;
    discard_d = discard_q;
    case (state_q)
      IDLE: begin
        if (branch_i) begin
          pc_d    = br_tgt;
          state_d = REQ;
        end else if (cnt_q < DEPTH_C) begin
          state_d = REQ;
        end
      end
      REQ: begin
        // The address on the bus must not move; park the target until the response drains.
        if (branch_i) begin
          discard_d = 1'b1;
          tgt_d     = br_tgt;
        end
        if (instr_gnt_i) state_d = WAIT_RV;
      end
      WAIT_RV: begin
        if (instr_rvalid_i) begin
          discard_d = 1'b0;
          if (branch_i) begin
            pc_d    = br_tgt;
            state_d = REQ;
          end else if (discard_q) begin
            pc_d    = tgt_q;
            state_d = REQ;
          end else begin
            pc_d    = pc_q + ADDR_WIDTH'(4);
            state_d = (cnt_d < DEPTH_C) ? REQ : IDLE;
          end
        end else if (branch_i) begin
          discard_d = 1'b1;
          tgt_d     = br_tgt;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= BOOT_ADDR;
      tgt_q     <= BOOT_ADDR;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      tgt_q     <= tgt_d;
      discard_q <= discard_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        addr_mem_q[i] <= '0;
        data_mem_q[i] <= '0;
      end
    end else if (branch_i) begin
      rptr_q <= '0;
      wptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push) begin
        addr_mem_q[wptr_q] <= pc_q;
        data_mem_q[wptr_q] <= instr_rdata_i;
        wptr_q             <= wptr_q + PW'(1);
      end
      if (pop) rptr_q <= rptr_q + PW'(1);
      cnt_q <= cnt_d;
    end
  end

endmodule
